// File: rtl/layer0_input_packer_if.sv
// layer0_input_packer_if: raw-feature input stream plus packed-frame output stream.
// master is the environment side (source + consumer), slave is the packer side.
interface layer0_input_packer_if #(
    parameter int IN_WIDTH   = 8,
    parameter int N_FEATURES = 48,
    parameter int OUT_BITS   = 2
);
    logic                           s_valid;
    logic                           s_ready;
    logic [IN_WIDTH-1:0]            s_data;
    logic                           s_last;
    logic                           m_valid;
    logic                           m_ready;
    logic [N_FEATURES*OUT_BITS-1:0] m_data;
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/layer0_input_packer.sv
// layer0_input_packer: quantizes raw features and packs N_FEATURES codes per frame,
// double-buffered so one frame fills while the previous one waits for the consumer.
module layer0_input_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int N_FEATURES = 48,
    parameter int OUT_BITS   = 2,
    parameter int SHIFT      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    layer0_input_packer_if.slave  bus,
    output logic                  err_short,
    output logic                  err_long,
    output logic [15:0]           err_cnt
);
    localparam int CNT_W = N_FEATURES > 1 ? $clog2(N_FEATURES) : 1;
    localparam int FW    = N_FEATURES * OUT_BITS;
    localparam logic [IN_WIDTH-1:0] QMAX = IN_WIDTH'((1 << OUT_BITS) - 1);
    typedef enum logic [1:0] {FILL, HOLD, DROP} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]     fill_q, fill_d, m_data_q, m_data_d, frame;
    logic              m_valid_q, m_valid_d;
    logic              err_short_q, err_short_d, err_long_q, err_long_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [IN_WIDTH-1:0] q;
    logic [OUT_BITS-1:0] code;
    logic s_ready, fill_in, at_end, consumed, done, load_now, short_err, long_err;
    assign q    = bus.s_data >> SHIFT;
    assign code = q > QMAX ? QMAX[OUT_BITS-1:0] : q[OUT_BITS-1:0];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            fill_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_cnt_q   <= err_cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (fill_in && at_end) state_d = !bus.s_last ? DROP : load_now ? FILL : HOLD;
            HOLD: if (consumed) state_d = FILL;
            DROP: if (bus.s_valid && bus.s_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end
    always_comb begin
        s_ready   = state_q != HOLD;
        fill_in   = bus.s_valid && state_q == FILL;
        at_end    = cnt_q == CNT_W'(N_FEATURES - 1);
        consumed  = m_valid_q && bus.m_ready;
        frame     = fill_q;
        frame[OUT_BITS*int'(cnt_q) +: OUT_BITS] = code;
        done      = fill_in && at_end && bus.s_last;
        load_now  = done && (!m_valid_q || consumed);
        short_err = fill_in && !at_end && bus.s_last;
        long_err  = fill_in && at_end && !bus.s_last;
        fill_d    = fill_in ? frame : fill_q;
        // count is already zero in HOLD and DROP, so only FILL beats move it
        cnt_d     = fill_in ? ((bus.s_last || at_end) ? '0 : cnt_q + 1'b1) : cnt_q;
        m_data_d  = load_now ? frame : (state_q == HOLD && consumed) ? fill_q : m_data_q;
        m_valid_d = load_now || state_q == HOLD || (m_valid_q && !bus.m_ready);
        err_short_d = short_err;
        err_long_d  = long_err;
        err_cnt_d   = (short_err || long_err) && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;
    end
    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_cnt     = err_cnt_q;
endmodule
